// File: rtl/i2c_slave_regbank.sv
// I2C slave register bank: sequential address lookup over an address list,
// then strobed per-byte read/write with an auto-incrementing byte pointer,
// read prefetch, per-entry write protection and sticky error flags.
module i2c_slave_regbank #(
  parameter int unsigned ADDRESSLENGTH = 7,
  parameter int unsigned ADDRESSNUM    = 4,
  parameter int unsigned NBYTES        = 2,
  parameter logic [ADDRESSNUM-1:0] WPMASK = '0,
  localparam int unsigned IDW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1,
  localparam int unsigned BIW = $clog2(NBYTES) + 1
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              AddrValid,
  input  logic [ADDRESSLENGTH-1:0]          DirectionBuffer,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
  input  logic                              ByteStrobe,
  input  logic                              RorW,
  input  logic                              Stop,
  input  logic [7:0]                        InputBuffer,
  output logic [7:0]                        OutputBuffer,
  output logic                              AddressFound,
  output logic                              Busy,
  output logic [IDW-1:0]                    LocalAddressID,
  output logic [BIW-1:0]                    ByteIndex,
  output logic                              WrapFlag,
  output logic                              WpErr,
  output logic [8*NBYTES*ADDRESSNUM-1:0]    Data
);

  typedef enum logic [1:0] {StIdle, StLookup, StMatched, StMiss} state_e;

  state_e                            state_q;
  logic [ADDRESSLENGTH-1:0]          addr_q;
  logic [IDW-1:0]                    scan_q;

  logic [ADDRESSLENGTH-1:0]          cur_entry;
  logic [7:0]                        first_byte;
  logic                              wp_hit;
  logic                              hit;
  logic                              wrap;
  logic                              wr_en;
  logic [BIW-1:0]                    bi_nxt;
  logic [8*NBYTES*ADDRESSNUM-1:0]    data_nxt;
  logic [7:0]                        rd_byte;

  assign hit    = (cur_entry == addr_q);
  assign wrap   = (ByteIndex == BIW'(NBYTES - 1));
  assign bi_nxt = wrap ? '0 : ByteIndex + 1'b1;
  assign wr_en  = (state_q == StMatched) && ByteStrobe && RorW && !wp_hit;

  // Select the list entry under scan, its prefetch byte, and the protection bit of the match.
  always_comb begin
    cur_entry  = '0;
    first_byte = '0;
    wp_hit     = 1'b0;
    for (int i = 0; i < ADDRESSNUM; i++) begin
      if (scan_q == IDW'(i)) begin
        cur_entry  = AddressList[i*ADDRESSLENGTH +: ADDRESSLENGTH];
        first_byte = Data[i*NBYTES*8 +: 8];
      end
      if (LocalAddressID == IDW'(i)) begin
        wp_hit = WPMASK[i];
      end
    end
  end

  // Memory after the pending write, and the byte at the advanced pointer read from it.
  always_comb begin
    data_nxt = Data;
    rd_byte  = '0;
    for (int i = 0; i < ADDRESSNUM; i++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_en && LocalAddressID == IDW'(i) && ByteIndex == BIW'(b)) begin
          data_nxt[(i*NBYTES+b)*8 +: 8] = InputBuffer;
        end
      end
    end
    for (int i = 0; i < ADDRESSNUM; i++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (LocalAddressID == IDW'(i) && bi_nxt == BIW'(b)) begin
          rd_byte = data_nxt[(i*NBYTES+b)*8 +: 8];
        end
      end
    end
  end

  // Protocol FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      scan_q         <= '0;
      Data           <= '0;
      OutputBuffer   <= '0;
      LocalAddressID <= '0;
      ByteIndex      <= '0;
      AddressFound   <= 1'b0;
      Busy           <= 1'b0;
      WrapFlag       <= 1'b0;
      WpErr          <= 1'b0;
    end else if (AddrValid) begin
      // A new address restarts the lookup and drops any same-cycle strobe or stop.
      state_q      <= StLookup;
      addr_q       <= DirectionBuffer;
      scan_q       <= '0;
      ByteIndex    <= '0;
      AddressFound <= 1'b0;
      Busy         <= 1'b1;
      WrapFlag     <= 1'b0;
      WpErr        <= 1'b0;
    end else begin
      case (state_q)
        StLookup: begin
          if (Stop) begin
            state_q   <= StIdle;
            Busy      <= 1'b0;
            ByteIndex <= '0;
          end else if (hit) begin
            state_q        <= StMatched;
            LocalAddressID <= scan_q;
            OutputBuffer   <= first_byte;
            AddressFound   <= 1'b1;
            Busy           <= 1'b0;
          end else if (scan_q == IDW'(ADDRESSNUM - 1)) begin
            state_q      <= StMiss;
            AddressFound <= 1'b0;
            Busy         <= 1'b0;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end
        StMatched: begin
          if (ByteStrobe) begin
            Data         <= data_nxt;
            OutputBuffer <= rd_byte;
            ByteIndex    <= bi_nxt;
            if (wrap) WrapFlag <= 1'b1;
            if (RorW && wp_hit) WpErr <= 1'b1;
          end
          // Stop after the byte: the pointer reset below overrides the increment.
          if (Stop) begin
            state_q      <= StIdle;
            AddressFound <= 1'b0;
            ByteIndex    <= '0;
          end
        end
        default: begin
          if (Stop) begin
            state_q      <= StIdle;
            AddressFound <= 1'b0;
            ByteIndex    <= '0;
          end
        end
      endcase
    end
  end

endmodule
